// File: rtl/clock_divisor_pkg.sv
// ----------------------------------------------------------------------------
// clock_divisor_pkg
// Shared constants and elaboration-time helpers for the clock divisor.
//   DEF_IN_FREQ_HZ / DEF_FAST_FREQ_HZ / DEF_SLOW_FREQ_HZ : default frequencies
//   half_period(in_hz, out_hz) : input cycles per half period of the output
//   cnt_width(half)            : counter width needed to count 0..half-1
//   ratio_ok(in_hz, out_hz)    : 1 when in_hz is an exact even multiple of out_hz
// No ports (package).
// ----------------------------------------------------------------------------
package clock_divisor_pkg;

  localparam int unsigned DEF_IN_FREQ_HZ   = 1_000_000;
  localparam int unsigned DEF_FAST_FREQ_HZ = 100_000;
  localparam int unsigned DEF_SLOW_FREQ_HZ = 10_000;

  function automatic int unsigned half_period(input int unsigned in_hz,
                                              input int unsigned out_hz);
    if (out_hz == 0) return 0;
    return in_hz / (2 * out_hz);
  endfunction

  // A half period of one cycle still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned half);
    if (half <= 1) return 1;
    return $clog2(half);
  endfunction

  // Zero output frequency is rejected before the modulo is evaluated.
  function automatic bit ratio_ok(input int unsigned in_hz,
                                  input int unsigned out_hz);
    if (out_hz == 0) return 1'b0;
    if (in_hz < 2 * out_hz) return 1'b0;
    return (in_hz % (2 * out_hz)) == 0;
  endfunction

endpackage

// File: rtl/clk_div_stage.sv
// ----------------------------------------------------------------------------
// clk_div_stage
// One divide-by-(2*HALF) stage: a free-running up-counter that wraps at
// HALF-1 and toggles a registered output on every wrap, giving a 50% duty
// square wave. Optional one-cycle tick on each rising edge of the output.
// Optional feature macro: CLOCK_DIVISOR_TICK_EN (adds tick_o).
// Ports:
//   clk_i   in   system clock, rising edge
//   srst_i  in   synchronous active-high reset
//   div_o   out  divided clock, driven directly from a flop
//   tick_o  out  (CLOCK_DIVISOR_TICK_EN) strobe coincident with div_o rising
// ----------------------------------------------------------------------------
module clk_div_stage
  import clock_divisor_pkg::*;
#(
  parameter int unsigned HALF = 5
) (
  input  logic clk_i,
  input  logic srst_i,
  output logic div_o
`ifdef CLOCK_DIVISOR_TICK_EN
  ,
  output logic tick_o
`endif
);

  localparam int unsigned    W    = cnt_width(HALF);
  localparam logic [W-1:0]   TERM = W'(HALF - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         div_q, div_d;
  logic         wrap;

  always_comb begin
    wrap  = (cnt_q == TERM);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    div_d = wrap ? ~div_q : div_q;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign div_o = div_q;

`ifdef CLOCK_DIVISOR_TICK_EN
  logic tick_q, tick_d;

  // A wrap while the output is low is exactly the edge where it rises, so the
  // registered tick lands on the same clock edge as the output rise.
  always_comb begin
    tick_d = wrap & ~div_q;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;
`endif

endmodule

// File: rtl/clock_divisor.sv
// ----------------------------------------------------------------------------
// clock_divisor
// Derives clk_100KHz (IN/FAST) and clk_10KHz (IN/SLOW) 50% duty clocks from
// clock1M using two independent counter/toggle stages. This level only checks
// the frequency ratios at elaboration and wires the stages to the ports.
// Optional feature macro: CLOCK_DIVISOR_TICK_EN (adds tick_* strobes).
// Ports:
//   clock1M      in   system clock, all logic on its rising edge
//   reset        in   synchronous active-high reset
//   clk_10KHz    out  IN/SLOW divided clock
//   clk_100KHz   out  IN/FAST divided clock
//   tick_10KHz   out  (CLOCK_DIVISOR_TICK_EN) 1-cycle strobe on clk_10KHz rise
//   tick_100KHz  out  (CLOCK_DIVISOR_TICK_EN) 1-cycle strobe on clk_100KHz rise
// ----------------------------------------------------------------------------
module clock_divisor
  import clock_divisor_pkg::*;
#(
  parameter int unsigned IN_FREQ_HZ   = DEF_IN_FREQ_HZ,
  parameter int unsigned FAST_FREQ_HZ = DEF_FAST_FREQ_HZ,
  parameter int unsigned SLOW_FREQ_HZ = DEF_SLOW_FREQ_HZ
) (
  input  logic clock1M,
  input  logic reset,
  output logic clk_10KHz,
  output logic clk_100KHz
`ifdef CLOCK_DIVISOR_TICK_EN
  ,
  output logic tick_10KHz,
  output logic tick_100KHz
`endif
);

  localparam int unsigned HALF_FAST = half_period(IN_FREQ_HZ, FAST_FREQ_HZ);
  localparam int unsigned HALF_SLOW = half_period(IN_FREQ_HZ, SLOW_FREQ_HZ);

  if (!ratio_ok(IN_FREQ_HZ, FAST_FREQ_HZ)) begin : g_bad_fast
    $error("clock_divisor: IN_FREQ_HZ must be an exact even multiple of FAST_FREQ_HZ");
  end
  if (!ratio_ok(IN_FREQ_HZ, SLOW_FREQ_HZ)) begin : g_bad_slow
    $error("clock_divisor: IN_FREQ_HZ must be an exact even multiple of SLOW_FREQ_HZ");
  end

  // Index 0 is the fast stage, index 1 the slow stage.
  logic [1:0] div_w;
`ifdef CLOCK_DIVISOR_TICK_EN
  logic [1:0] tick_w;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_stage
    clk_div_stage #(
      .HALF((gi == 0) ? HALF_FAST : HALF_SLOW)
    ) u_stage (
      .clk_i  (clock1M),
      .srst_i (reset),
      .div_o  (div_w[gi])
`ifdef CLOCK_DIVISOR_TICK_EN
      ,
      .tick_o (tick_w[gi])
`endif
    );
  end

  assign clk_100KHz = div_w[0];
  assign clk_10KHz  = div_w[1];
`ifdef CLOCK_DIVISOR_TICK_EN
  assign tick_100KHz = tick_w[0];
  assign tick_10KHz  = tick_w[1];
`endif

endmodule

// File: tb/tb_clock_divisor.sv
// ----------------------------------------------------------------------------
// tb_clock_divisor
// Scoreboard bench: the stimulus process drives reset each cycle and pushes
// the expected outputs after the coming edge; a monitor pops and compares
// one entry per clock1M edge and gathers toggle / run-length statistics over
// the 1000-cycle window.
// ----------------------------------------------------------------------------
module tb_clock_divisor;

  logic clock1M;
  logic reset;
  logic clk_10KHz;
  logic clk_100KHz;
`ifdef CLOCK_DIVISOR_TICK_EN
  logic tick_10KHz;
  logic tick_100KHz;
`endif

  clock_divisor dut (
    .clock1M    (clock1M),
    .reset      (reset),
    .clk_10KHz  (clk_10KHz),
    .clk_100KHz (clk_100KHz)
`ifdef CLOCK_DIVISOR_TICK_EN
    ,
    .tick_10KHz (tick_10KHz),
    .tick_100KHz(tick_100KHz)
`endif
  );

  initial begin
    clock1M = 1'b0;
    forever #5 clock1M = ~clock1M;
  end

  typedef struct {
    logic fast;
    logic slow;
    logic tf;
    logic ts;
    bit   win;
    int   n;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   armed    = 1'b0;
  int   n_edge   = 0;

  // Statistics over the 1000-cycle window
  int tog_f = 0, tog_s = 0, run_f = 0, run_s = 0, tick_cnt_f = 0, tick_cnt_s = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req, input int n);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d required=%0d", nm, n, act, req);
    end
  endtask

  // Expected values are closed-form in the edge count since release:
  // fast high for n in [5,10) mod 10, slow high for n in [50,100) mod 100.
  task automatic step(input bit rst, input bit win);
    exp_t e;
    @(negedge clock1M);
    reset = rst;
    if (rst) n_edge = 0;
    else     n_edge = n_edge + 1;
    e.n    = n_edge;
    e.fast = ((n_edge / 5) % 2) == 1;
    e.slow = ((n_edge / 50) % 2) == 1;
    e.tf   = !rst && ((n_edge % 10) == 5);
    e.ts   = !rst && ((n_edge % 100) == 50);
    e.win  = win;
    q.push_back(e);
    armed = 1'b1;
    $display("step edge=%0d reset=%0b exp_fast=%0b exp_slow=%0b", e.n, rst, e.fast, e.slow);
    @(posedge clock1M);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    logic prev_f, prev_s;
    prev_f = 1'b0;
    prev_s = 1'b0;
    forever begin
      @(posedge clock1M);
      #1;
      if (armed) begin
        if (q.size() == 0) begin
          chk("queue_underflow", 32'd1, 32'd0, -1);
        end else begin
          e = q.pop_front();
          chk("clk_100KHz", {31'd0, clk_100KHz}, {31'd0, e.fast}, e.n);
          chk("clk_10KHz",  {31'd0, clk_10KHz},  {31'd0, e.slow}, e.n);
`ifdef CLOCK_DIVISOR_TICK_EN
          chk("tick_100KHz", {31'd0, tick_100KHz}, {31'd0, e.tf}, e.n);
          chk("tick_10KHz",  {31'd0, tick_10KHz},  {31'd0, e.ts}, e.n);
`endif
          if (e.win) begin
            if (clk_100KHz !== prev_f) tog_f++;
            if (clk_10KHz  !== prev_s) tog_s++;
            if (clk_100KHz === 1'b1) run_f++;
            else if (prev_f === 1'b1) begin
              chk("fast_high_run", run_f, 32'd5, e.n);
              run_f = 0;
            end
            if (clk_10KHz === 1'b1) run_s++;
            else if (prev_s === 1'b1) begin
              chk("slow_high_run", run_s, 32'd50, e.n);
              run_s = 0;
            end
`ifdef CLOCK_DIVISOR_TICK_EN
            if (tick_100KHz === 1'b1) tick_cnt_f++;
            if (tick_10KHz  === 1'b1) tick_cnt_s++;
            chk("tick_fast_on_rise", {31'd0, tick_100KHz},
                {31'd0, (clk_100KHz === 1'b1) && (prev_f === 1'b0)}, e.n);
            chk("tick_slow_on_rise", {31'd0, tick_10KHz},
                {31'd0, (clk_10KHz === 1'b1) && (prev_s === 1'b0)}, e.n);
`endif
            if (e.n == 50) begin
              chk("edge50_phase", {28'd0, prev_f, clk_100KHz, prev_s, clk_10KHz},
                  32'b1001, e.n);
            end
          end
          prev_f = clk_100KHz;
          prev_s = clk_10KHz;
        end
      end
    end
  end

  // Outputs may only move in the time step of a clock1M rising edge.
  time last_pos = 0;
  always @(posedge clock1M) last_pos = $time;

  always @(clk_100KHz or clk_10KHz) begin
    if (armed) chk("change_off_edge", {31'd0, ($time == last_pos)}, 32'd1, -1);
  end
`ifdef CLOCK_DIVISOR_TICK_EN
  always @(tick_100KHz or tick_10KHz) begin
    if (armed) chk("tick_change_off_edge", {31'd0, ($time == last_pos)}, 32'd1, -1);
  end
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset = 1'b1;
    // Two reset cycles, then a 1000-cycle free run
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b0, 1'b1);
    // Fresh start, then a one-cycle reset at edge 73 and a restart
    step(1'b1, 1'b0);
    for (int i = 0; i < 72; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0);
    #2;
    chk("queue_drained", q.size(), 32'd0, -1);
    chk("fast_toggles", tog_f, 32'd200, -1);
    chk("slow_toggles", tog_s, 32'd20, -1);
`ifdef CLOCK_DIVISOR_TICK_EN
    chk("fast_tick_count", tick_cnt_f, 32'd100, -1);
    chk("slow_tick_count", tick_cnt_s, 32'd10, -1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
